instruction_memory_param: RTL



---
 rtl/instruction_memory_param.sv | 115 +++++++++++
 1 files changed

// File: rtl/instruction_memory_param.sv
// Parametrised instruction store: self-initialises after reset, then serves fetches
// through a registered valid/ready read port, with a run-time load port and fault flag.
module instruction_memory_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int INIT_MULT  = 3,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [31:0]           Address,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  Fault,
    input  logic                  LoadEn,
    input  logic [31:0]           LoadAddr,
    input  logic [DATA_WIDTH-1:0] LoadData,
    output logic                  InitDone
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_fault;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_fetch_bad;
    logic                  w_load_bad;
    logic [IDX_W-1:0]      w_fetch_idx;
    logic [IDX_W-1:0]      w_load_idx;
    logic [DATA_WIDTH-1:0] w_init_word;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_data;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (|a[31:IDX_W+2]);
    endfunction

    assign w_fetch_bad = addr_bad(Address);
    assign w_load_bad  = addr_bad(LoadAddr);
    assign w_fetch_idx = Address[IDX_W+1:2];
    assign w_load_idx  = LoadAddr[IDX_W+1:2];
    assign w_init_word = DATA_WIDTH'(64'(r_ptr) * 64'(INIT_MULT));

    assign w_req_ready = (r_state == ST_READY) && (!r_resp_valid || RespReady);
    assign w_accept    = ReqValid && w_req_ready;

    // Single write port shared by the init sweep and the load port; loads only in READY.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_idx  = r_ptr;
        w_mem_data = w_init_word;
        if (!Reset) begin
            if (r_state == ST_INIT) begin
                w_mem_we = 1'b1;
            end else if (LoadEn && !w_load_bad) begin
                w_mem_we   = 1'b1;
                w_mem_idx  = w_load_idx;
                w_mem_data = LoadData;
            end
        end
    end

    // Memory is not reset; the response register reads the pre-write contents.
    always_ff @(posedge Clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_INIT;
            r_ptr        <= '0;
            r_resp_valid <= 1'b0;
            r_instr      <= '0;
            r_fault      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + IDX_W'(1);
                    if (r_ptr == IDX_W'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                    end
                end
                ST_READY: r_state <= ST_READY;
                default:  r_state <= ST_INIT;
            endcase

            if (w_accept) begin
                r_resp_valid <= 1'b1;
                r_fault      <= w_fetch_bad;
                r_instr      <= w_fetch_bad ? '0 : r_mem[w_fetch_idx];
            end else if (RespReady) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign ReqReady    = w_req_ready;
    assign RespValid   = r_resp_valid;
    assign Instruction = r_instr;
    assign Fault       = r_fault;
    assign InitDone    = (r_state == ST_READY);

endmodule
